tcam_route_loader: RTL and testbench

Control-plane writer for the route-lookup TCAM. Accepts add, clear and (optionally) delete route commands over a valid/ready handshake. Converts prefix/length into the TCAM entry format and tracks slot occupancy. Drives the TCAM write port (`wr_en`, `wr_index`, `addr_in`) and returns a per-command status response; sits between the host/management interface and the TCAM.

---
 rtl/tcam_route_loader.sv | 274 +++++++++++++++++++++++++++
 tb/tb_tcam_route_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tcam_route_loader.sv
// tcam_route_loader: control-plane writer for the route-lookup TCAM.
// Accepts add / clear-all (and delete when ROUTE_DEL_EN is defined) commands,
// converts prefix/length into {network, mask, if_idx} entries, tracks slot
// occupancy and returns one status response per command.
// Build option: ROUTE_DEL_EN adds a per-slot {network, len} shadow store,
// the SEARCH state and the delete op (2'b10).
module tcam_route_loader #(
  parameter int SIZE  = 32,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_prefix,
  input  logic [5:0]       cmd_len,
  input  logic [3:0]       cmd_if,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_ok,
  output logic [IDX_W-1:0] rsp_index,
  output logic             tcam_wr_en,
  output logic [IDX_W-1:0] tcam_wr_index,
  output logic [67:0]      tcam_wr_data,
  output logic [IDX_W-1:0] route_count
);

  localparam int SW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
`ifdef ROUTE_DEL_EN
    SEARCH,
`endif
    WRITE,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              clr_q, clr_d;
  logic [SIZE-1:0]   occ_q, occ_d;
  logic [IDX_W-1:0]  count_d;
  logic [IDX_W-1:0]  pend_q, pend_d;
  logic              rsp_valid_d, rsp_ok_d;
  logic [IDX_W-1:0]  rsp_index_d;
  logic              wr_en_d;
  logic [IDX_W-1:0]  wr_index_d;
  logic [67:0]       wr_data_d;

  logic [31:0]       mask, net;
  logic              len_ok, any_free;
  logic [SW-1:0]     free_idx;

`ifdef ROUTE_DEL_EN
  logic [31:0]       sh_net [SIZE];
  logic [5:0]        sh_len [SIZE];
  logic [31:0]       key_net_q, key_net_d;
  logic [5:0]        key_len_q, key_len_d;
  logic              sh_wr, sh_clr_all, sh_clr_one, hit;
  logic [SW-1:0]     slot;
`endif

  assign cmd_ready = (state_q == IDLE);

  // Command decode helpers: mask/network of the incoming prefix and lowest free slot.
  always_comb begin
    len_ok   = (cmd_len <= 6'd32);
    mask     = (cmd_len == 6'd0 || !len_ok) ? '0 : (32'hFFFF_FFFF << (6'd32 - cmd_len));
    net      = cmd_prefix & mask;
    any_free = ~&occ_q;
    free_idx = '0;
    // Scan from the top so the lowest free slot is the last one assigned.
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (!occ_q[SIZE-1-i]) free_idx = SW'(SIZE - 1 - i);
    end
  end

`ifdef ROUTE_DEL_EN
  assign slot = cnt_q[SW-1:0];
  assign hit  = occ_q[slot] && (sh_len[slot] == key_len_q) && (sh_net[slot] == key_net_q);
`endif

  // Next-state and next-output logic for the loader FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clr_d       = clr_q;
    occ_d       = occ_q;
    count_d     = route_count;
    pend_d      = pend_q;
    rsp_valid_d = rsp_valid;
    rsp_ok_d    = rsp_ok;
    rsp_index_d = rsp_index;
    wr_en_d     = 1'b0;
    wr_index_d  = tcam_wr_index;
    wr_data_d   = tcam_wr_data;
`ifdef ROUTE_DEL_EN
    key_net_d   = key_net_q;
    key_len_d   = key_len_q;
    sh_wr       = 1'b0;
    sh_clr_all  = 1'b0;
    sh_clr_one  = 1'b0;
`endif
    unique case (state_q)
      INIT: begin
        // The counter runs one past the last slot so cmd_ready follows the final strobe.
        if (cnt_q == CW'(SIZE)) begin
          cnt_d = '0;
          if (clr_q) begin
            clr_d       = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_ok_d    = 1'b1;
            rsp_index_d = '0;
            state_d     = RESP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          wr_en_d    = 1'b1;
          wr_index_d = IDX_W'(cnt_q);
          wr_data_d  = '0;
          cnt_d      = cnt_q + CW'(1);
        end
      end
      IDLE: begin
        if (cmd_valid) begin
          rsp_valid_d = 1'b1;
          rsp_ok_d    = 1'b0;
          rsp_index_d = '0;
          state_d     = RESP;
          unique case (cmd_op)
            2'b00: begin
              if (len_ok && any_free) begin
                rsp_valid_d     = 1'b0;
                wr_en_d         = 1'b1;
                wr_index_d      = IDX_W'(free_idx);
                wr_data_d       = {net, mask, cmd_if};
                occ_d[free_idx] = 1'b1;
                count_d         = route_count + IDX_W'(1);
                pend_d          = IDX_W'(free_idx);
                state_d         = WRITE;
`ifdef ROUTE_DEL_EN
                sh_wr           = 1'b1;
`endif
              end
            end
            2'b01: begin
              rsp_valid_d = 1'b0;
              occ_d       = '0;
              count_d     = '0;
              cnt_d       = '0;
              clr_d       = 1'b1;
              state_d     = INIT;
`ifdef ROUTE_DEL_EN
              sh_clr_all  = 1'b1;
`endif
            end
`ifdef ROUTE_DEL_EN
            2'b10: begin
              rsp_valid_d = 1'b0;
              key_net_d   = net;
              key_len_d   = cmd_len;
              cnt_d       = '0;
              state_d     = SEARCH;
            end
`endif
            default: ;
          endcase
        end
      end
`ifdef ROUTE_DEL_EN
      SEARCH: begin
        if (hit) begin
          wr_en_d     = 1'b1;
          wr_index_d  = IDX_W'(slot);
          wr_data_d   = '0;
          occ_d[slot] = 1'b0;
          count_d     = route_count - IDX_W'(1);
          pend_d      = IDX_W'(slot);
          sh_clr_one  = 1'b1;
          state_d     = WRITE;
        end else if (cnt_q == CW'(SIZE - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_ok_d    = 1'b0;
          rsp_index_d = '0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      WRITE: begin
        rsp_valid_d = 1'b1;
        rsp_ok_d    = 1'b1;
        rsp_index_d = pend_q;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= INIT;
      cnt_q         <= '0;
      clr_q         <= 1'b0;
      occ_q         <= '0;
      route_count   <= '0;
      pend_q        <= '0;
      rsp_valid     <= 1'b0;
      rsp_ok        <= 1'b0;
      rsp_index     <= '0;
      tcam_wr_en    <= 1'b0;
      tcam_wr_index <= '0;
      tcam_wr_data  <= '0;
`ifdef ROUTE_DEL_EN
      key_net_q     <= '0;
      key_len_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      clr_q         <= clr_d;
      occ_q         <= occ_d;
      route_count   <= count_d;
      pend_q        <= pend_d;
      rsp_valid     <= rsp_valid_d;
      rsp_ok        <= rsp_ok_d;
      rsp_index     <= rsp_index_d;
      tcam_wr_en    <= wr_en_d;
      tcam_wr_index <= wr_index_d;
      tcam_wr_data  <= wr_data_d;
`ifdef ROUTE_DEL_EN
      key_net_q     <= key_net_d;
      key_len_q     <= key_len_d;
`endif
    end
  end

`ifdef ROUTE_DEL_EN
  // Shadow store of {network, len} per slot, used to match delete requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SIZE; i++) begin
        sh_net[i] <= '0;
        sh_len[i] <= '0;
      end
    end else if (sh_clr_all) begin
      for (int unsigned i = 0; i < SIZE; i++) begin
        sh_net[i] <= '0;
        sh_len[i] <= '0;
      end
    end else if (sh_wr) begin
      sh_net[free_idx] <= net;
      sh_len[free_idx] <= cmd_len;
    end else if (sh_clr_one) begin
      sh_net[slot] <= '0;
      sh_len[slot] <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_tcam_route_loader.sv
// Directed self-checking bench for tcam_route_loader (SIZE=32).
module tb_tcam_route_loader;
  localparam int SIZE  = 32;
  localparam int IDX_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [31:0]      cmd_prefix;
  logic [5:0]       cmd_len;
  logic [3:0]       cmd_if;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_ok;
  logic [IDX_W-1:0] rsp_index;
  logic             tcam_wr_en;
  logic [IDX_W-1:0] tcam_wr_index;
  logic [67:0]      tcam_wr_data;
  logic [IDX_W-1:0] route_count;

  int tests   = 0;
  int fails   = 0;
  int overlap = 0;
  logic [75:0] strobes [$];

  always #5 clk = ~clk;

  tcam_route_loader #(.SIZE(SIZE), .IDX_W(IDX_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_prefix    (cmd_prefix),
    .cmd_len       (cmd_len),
    .cmd_if        (cmd_if),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_ok        (rsp_ok),
    .rsp_index     (rsp_index),
    .tcam_wr_en    (tcam_wr_en),
    .tcam_wr_index (tcam_wr_index),
    .tcam_wr_data  (tcam_wr_data),
    .route_count   (route_count)
  );

  // Record every TCAM write strobe; cmd_ready must never coincide with one.
  always @(negedge clk) begin
    if (!rst && tcam_wr_en) begin
      strobes.push_back({tcam_wr_index, tcam_wr_data});
      if (cmd_ready) overlap++;
    end
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [75:0] strobe_at(input int i);
    if (i < strobes.size()) return strobes[i];
    return '1;
  endfunction

  task automatic wait_ready(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cmd_ready && lat < 200);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [31:0] pfx, input logic [5:0] len,
                        input logic [3:0] ifx, input bit ack,
                        output logic ok, output logic [IDX_W-1:0] idx, output int lat);
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_prefix = pfx;
    cmd_len    = len;
    cmd_if     = ifx;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    strobes.delete();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 200);
    if (!rsp_valid) check("rsp_timeout", 1'b0, 1'b1);
    ok  = rsp_ok;
    idx = rsp_index;
    if (ack) begin
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  initial begin
    logic             ok;
    logic [IDX_W-1:0] idx;
    int               lat;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_prefix = '0;
    cmd_len = '0; cmd_if = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_ok", rsp_ok, 1'b0);
    check("rst_rsp_index", rsp_index, '0);
    check("rst_wr_en", tcam_wr_en, 1'b0);
    check("rst_wr_index", tcam_wr_index, '0);
    check("rst_wr_data", tcam_wr_data, '0);
    check("rst_count", route_count, '0);

    // Reset sweep
    strobes.delete();
    rst = 1'b0;
    wait_ready(lat);
    check("init_lat", lat, 33);
    check("init_strobes", strobes.size(), 32);
    for (int i = 0; i < 32; i++) check("init_strobe", strobe_at(i), {8'(i), 68'h0});
    check("init_count", route_count, '0);

    // Add 192.168.0.0/24 if 2
    do_cmd(2'b00, 32'hc0a80000, 6'd24, 4'h2, 1'b1, ok, idx, lat);
    check("add1_lat", lat, 2);
    check("add1_ok", ok, 1'b1);
    check("add1_idx", idx, 8'd0);
    check("add1_nstrobe", strobes.size(), 1);
    check("add1_data", strobe_at(0), {8'd0, 32'hc0a80000, 32'hffffff00, 4'h2});
    check("add1_count", route_count, 8'd1);

    // Add 10.0.0.7/8 if 1: host bits masked off
    do_cmd(2'b00, 32'h0a000007, 6'd8, 4'h1, 1'b1, ok, idx, lat);
    check("add2_ok", ok, 1'b1);
    check("add2_idx", idx, 8'd1);
    check("add2_data", strobe_at(0), {8'd1, 32'h0a000000, 32'hff000000, 4'h1});
    check("add2_count", route_count, 8'd2);

    // Length 33 rejected
    do_cmd(2'b00, 32'h0a000007, 6'd33, 4'h1, 1'b1, ok, idx, lat);
    check("len33_lat", lat, 1);
    check("len33_ok", ok, 1'b0);
    check("len33_idx", idx, 8'd0);
    check("len33_nstrobe", strobes.size(), 0);
    check("len33_count", route_count, 8'd2);

    // Reserved op
    do_cmd(2'b11, 32'h01020304, 6'd16, 4'h3, 1'b1, ok, idx, lat);
    check("rsvd_lat", lat, 1);
    check("rsvd_ok", ok, 1'b0);
    check("rsvd_nstrobe", strobes.size(), 0);

`ifdef ROUTE_DEL_EN
    do_cmd(2'b10, 32'h0a000000, 6'd8, 4'h0, 1'b1, ok, idx, lat);
    check("del_lat", lat, 4);
    check("del_ok", ok, 1'b1);
    check("del_idx", idx, 8'd1);
    check("del_nstrobe", strobes.size(), 1);
    check("del_data", strobe_at(0), {8'd1, 68'h0});
    check("del_count", route_count, 8'd1);
    do_cmd(2'b10, 32'h0a000000, 6'd8, 4'h0, 1'b1, ok, idx, lat);
    check("del2_lat", lat, 33);
    check("del2_ok", ok, 1'b0);
    check("del2_nstrobe", strobes.size(), 0);
    check("del2_count", route_count, 8'd1);
    do_cmd(2'b00, 32'h0a000007, 6'd8, 4'h1, 1'b1, ok, idx, lat);
    check("reuse_idx", idx, 8'd1);
    check("reuse_count", route_count, 8'd2);
`else
    do_cmd(2'b10, 32'h0a000000, 6'd8, 4'h0, 1'b1, ok, idx, lat);
    check("del_off_lat", lat, 1);
    check("del_off_ok", ok, 1'b0);
    check("del_off_nstrobe", strobes.size(), 0);
    check("del_off_count", route_count, 8'd2);
`endif

    // Fill the remaining slots
    for (int i = 2; i < 32; i++) begin
      do_cmd(2'b00, {8'(i), 24'h123456}, 6'd8, 4'(i), 1'b1, ok, idx, lat);
      check("fill_ok", ok, 1'b1);
      check("fill_idx", idx, 8'(i));
      check("fill_data", strobe_at(0), {8'(i), 8'(i), 24'h0, 32'hff000000, 4'(i)});
    end
    check("full_count", route_count, 8'd32);

    // Table full
    do_cmd(2'b00, 32'h0c000000, 6'd8, 4'h5, 1'b1, ok, idx, lat);
    check("full_lat", lat, 1);
    check("full_ok", ok, 1'b0);
    check("full_nstrobe", strobes.size(), 0);
    check("full_count2", route_count, 8'd32);

    // Clear-all
    do_cmd(2'b01, 32'h0, 6'd0, 4'h0, 1'b1, ok, idx, lat);
    check("clr_lat", lat, 34);
    check("clr_ok", ok, 1'b1);
    check("clr_idx", idx, 8'd0);
    check("clr_nstrobe", strobes.size(), 32);
    for (int i = 0; i < 32; i++) check("clr_strobe", strobe_at(i), {8'(i), 68'h0});
    check("clr_count", route_count, 8'd0);

    // Default route (len 0) lands in slot 0 after clear
    do_cmd(2'b00, 32'hdeadbeef, 6'd0, 4'h7, 1'b1, ok, idx, lat);
    check("len0_idx", idx, 8'd0);
    check("len0_data", strobe_at(0), {8'd0, 68'h7});
    check("len0_count", route_count, 8'd1);

    // Response held without rsp_ready, then reset mid-hold
    do_cmd(2'b00, 32'h0b0000ff, 6'd16, 4'h9, 1'b0, ok, idx, lat);
    check("hold_ok", ok, 1'b1);
    check("hold_idx", idx, 8'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_rsp_ok", rsp_ok, 1'b1);
      check("hold_rsp_idx", rsp_index, 8'd1);
      check("hold_cmd_ready", cmd_ready, 1'b0);
    end
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", rsp_valid, 1'b0);
    check("mid_rst_count", route_count, 8'd0);
    check("mid_rst_wr_en", tcam_wr_en, 1'b0);
    @(negedge clk);
    strobes.delete();
    rst = 1'b0;
    wait_ready(lat);
    check("reinit_lat", lat, 33);
    check("reinit_nstrobe", strobes.size(), 32);
    check("reinit_first", strobe_at(0), {8'd0, 68'h0});
    check("reinit_last", strobe_at(31), {8'd31, 68'h0});
    check("ready_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
